// File: rtl/tfm_config.sv
// Config-port stage ahead of the bus access sequencer: decodes Fx writes into chip selects,
// defers them while an access is in flight, and generates chip reset and (TFM_SAACLK_EN) saa_clk.
module tfm_config #(
  parameter int RST_CYCLES = 1024,
  parameter int SAA_DIV    = 7,
  parameter int SAA_HI     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_port,
  input  logic [3:0] cfg_d,
  input  logic       acc_busy,
  output logic       ym_sel,
  output logic       ym_stat,
  output logic       saa_sel,
  output logic       cfg_pending,
  output logic       chip_rst_n,
  output logic       saa_clk
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [11:0] RST_LAST = 12'(RST_CYCLES - 1);

  // Out-of-range parameters fail elaboration on a missing module.
  if (RST_CYCLES < 2 || RST_CYCLES > 4095 || SAA_DIV < 2 || SAA_DIV > 15 ||
      SAA_HI < 1 || SAA_HI > SAA_DIV - 1) begin : g_bad_param
    tfm_config_illegal_parameter u_bad ();
  end

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;   // {saa_sel, ym_stat, ym_sel}
  logic [2:0]  shd_q, shd_d;
  logic [2:0]  dec;
  logic [11:0] rcnt_q, rcnt_d;
  logic        crst_q, crst_d;

  // Active-low nibble bits; bit 2 is reserved.
  assign dec = {~cfg_d[3], ~cfg_d[1], ~cfg_d[0]};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    shd_d   = shd_q;
    unique case (state_q)
      IDLE: begin
        if (wr_port) begin
          if (acc_busy) begin
            shd_d   = dec;
            state_d = PEND;
          end else begin
            sel_d = dec;
          end
        end
      end
      PEND: begin
        if (wr_port) begin
          shd_d = dec;
        end else if (!acc_busy) begin
          sel_d   = shd_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rcnt_d = rcnt_q;
    crst_d = crst_q;
    if (rcnt_q == RST_LAST) crst_d = 1'b1;
    else                    rcnt_d = rcnt_q + 12'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'b000;
      shd_q   <= 3'b000;
      rcnt_q  <= 12'd0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      shd_q   <= shd_d;
      rcnt_q  <= rcnt_d;
      crst_q  <= crst_d;
    end
  end

  assign ym_sel      = sel_q[0];
  assign ym_stat     = sel_q[1];
  assign saa_sel     = sel_q[2];
  assign cfg_pending = (state_q == PEND);
  assign chip_rst_n  = crst_q;

`ifdef TFM_SAACLK_EN
  logic [3:0] div_q, div_d;
  logic       saa_q, saa_d;

  // Free-running from reset release, independent of chip reset and config traffic.
  always_comb begin
    div_d = (div_q == 4'(SAA_DIV - 1)) ? 4'd0 : div_q + 4'd1;
    saa_d = (div_q < 4'(SAA_HI));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 4'd0;
      saa_q <= 1'b0;
    end else begin
      div_q <= div_d;
      saa_q <= saa_d;
    end
  end

  assign saa_clk = saa_q;
`else
  assign saa_clk = 1'b0;
`endif

endmodule
